// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op codes and op classification helpers for the pipelined shifter
package shifter_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_SLL = 3'b000;
  localparam op_t OP_SRL = 3'b001;
  localparam op_t OP_SRA = 3'b010;
  localparam op_t OP_ROL = 3'b011;
  localparam op_t OP_ROR = 3'b100;

  function automatic logic is_right(op_t op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic is_rot(op_t op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // Codes above OP_ROR are pass-through
  function automatic logic is_shift_op(op_t op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one combinational mux level: shift/rotate by DIST or pass through
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  op_t              op,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] sh_left;
  logic [WIDTH-1:0] sh_right;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;

  // fill is already 0 for everything except SRA with a negative operand
  assign sh_left   = {data[WIDTH-1-DIST:0], {DIST{1'b0}}};
  assign sh_right  = {{DIST{fill}}, data[WIDTH-1:DIST]};
  assign rot_left  = {data[WIDTH-1-DIST:0], data[WIDTH-1 -: DIST]};
  assign rot_right = {data[DIST-1:0], data[WIDTH-1:DIST]};

  always_comb begin
    result = data;
    if (en && is_shift_op(op)) begin
      if (is_rot(op)) begin
        result = is_right(op) ? rot_right : rot_left;
      end else begin
        result = is_right(op) ? sh_right : sh_left;
      end
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined barrel shift/rotate unit with valid/ready flow and tag passthrough
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int LVLS_PER_STG = 2,
  parameter int TAG_W        = 4,
  localparam int CNT_W       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  op_t              in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam int NSTG = (CNT_W + LVLS_PER_STG - 1) / LVLS_PER_STG;

  // Index s is the input side of stage s; index s+1 is the register of stage s.
  logic [WIDTH-1:0] stg_data  [NSTG+1];
  logic [TAG_W-1:0] stg_tag   [NSTG+1];
  logic             stg_valid [NSTG+1];
  logic             stg_ld    [NSTG+1];
  logic [CNT_W-1:0] stg_cnt   [NSTG];
  op_t              stg_op    [NSTG];
  logic             stg_fill  [NSTG];

  assign stg_data[0]  = in_data;
  assign stg_tag[0]   = in_tag;
  assign stg_valid[0] = in_valid;
  assign stg_cnt[0]   = in_cnt;
  assign stg_op[0]    = in_op;
  assign stg_fill[0]  = (in_op == OP_SRA) && in_data[WIDTH-1];
  assign stg_ld[NSTG] = out_ready;

  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    localparam int LO = s * LVLS_PER_STG;
    localparam int HI = ((s + 1) * LVLS_PER_STG < CNT_W) ? (s + 1) * LVLS_PER_STG : CNT_W;

    logic [WIDTH-1:0] chain [HI-LO+1];
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [TAG_W-1:0] tag_q;

    assign chain[0] = stg_data[s];

    for (genvar k = LO; k < HI; k++) begin : g_lvl
      shift_level #(
        .WIDTH (WIDTH),
        .DIST  (1 << k)
      ) u_level (
        .data   (chain[k-LO]),
        .en     (stg_cnt[s][k]),
        .op     (stg_op[s]),
        .fill   (stg_fill[s]),
        .result (chain[k-LO+1])
      );
    end

    // Load when empty or when the current contents move on this cycle
    assign stg_ld[s] = !stg_valid[s+1] || stg_ld[s+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else if (stg_ld[s]) begin
        valid_q <= stg_valid[s];
        if (stg_valid[s]) begin
          data_q <= chain[HI-LO];
          tag_q  <= stg_tag[s];
        end
      end
    end

    assign stg_valid[s+1] = valid_q;
    assign stg_data[s+1]  = data_q;
    assign stg_tag[s+1]   = tag_q;

    if (s < NSTG - 1) begin : g_ctl
      logic [CNT_W-1:0] cnt_q;
      op_t              op_q;
      logic             fill_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q  <= '0;
          op_q   <= OP_SLL;
          fill_q <= 1'b0;
        end else if (stg_ld[s] && stg_valid[s]) begin
          cnt_q  <= stg_cnt[s];
          op_q   <= stg_op[s];
          fill_q <= stg_fill[s];
        end
      end

      assign stg_cnt[s+1]  = cnt_q;
      assign stg_op[s+1]   = op_q;
      assign stg_fill[s+1] = fill_q;
    end
  end

  assign in_ready  = stg_ld[0];
  assign out_valid = stg_valid[NSTG];
  assign out_data  = stg_data[NSTG];
  assign out_tag   = stg_tag[NSTG];
  assign out_zero  = ~|out_data;

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - scoreboard bench: directed 16-bit cases plus random 32-bit runs
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int NRND = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit summary_done = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: shift/rotate by whole-word arithmetic
  function automatic logic [63:0] ref_model(input int w, input logic [63:0] d, input int c,
                                            input logic [2:0] op);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    d = d & mask;
    case (op)
      3'd0:    return (d << c) & mask;
      3'd1:    return d >> c;
      3'd2:    return d[w-1] ? ((d >> c) | (~(mask >> c) & mask)) : (d >> c);
      3'd3:    return ((d << c) | (d >> (w - c))) & mask;
      3'd4:    return ((d >> c) | (d << (w - c))) & mask;
      default: return d;
    endcase
  endfunction

  // ---------------- 16-bit DUT, directed ----------------
  logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
  logic [15:0] a_in_data, a_out_data;
  logic [3:0]  a_in_cnt, a_in_tag, a_out_tag;
  logic [2:0]  a_in_op;
  logic [19:0] a_q[$];
  int          a_out_cyc[$];
  int          a_pops = 0;
  int          a_last_out_cyc = 0;
  bit          a_done = 0;

  pipelined_shifter #(.WIDTH(16), .LVLS_PER_STG(2), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_cnt(a_in_cnt), .in_op(a_in_op), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .out_zero(a_out_zero)
  );

  always @(negedge clk) begin
    if (a_rst_n && a_out_valid && a_out_ready) begin
      if (a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_result: got data %0h tag %0h with nothing outstanding",
                 a_out_data, a_out_tag);
      end else begin
        logic [19:0] e;
        e = a_q.pop_front();
        check("a_data", a_out_data, e[15:0]);
        check("a_tag", a_out_tag, e[19:16]);
        check("a_zero", a_out_zero, e[15:0] == 16'h0);
      end
      a_pops++;
      a_last_out_cyc = cyc;
      a_out_cyc.push_back(cyc);
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic a_send(input logic [15:0] d, input logic [3:0] c, input logic [2:0] op,
                        input logic [3:0] tag, input logic [15:0] exp,
                        output int acc, output int waited);
    a_in_data = d; a_in_cnt = c; a_in_op = op; a_in_tag = tag; a_in_valid = 1'b1;
    acc = -1;
    waited = 0;
    for (int w = 0; w <= 100; w++) begin
      @(negedge clk);
      if (a_in_ready) begin
        a_q.push_back({tag, exp});
        acc = cyc;
        waited = w;
        break;
      end
      if (w == 100) begin
        checks++; errors++;
        $display("FAIL a_accept_timeout: tag %0h not accepted in 100 cycles", tag);
      end
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait_pops(input int n);
    for (int w = 0; w < 60 && a_pops < n; w++) begin
      @(negedge clk); #1;
    end
    check("a_result_count", a_pops, n);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, waited, p0;
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_cnt = '0; a_in_op = '0;
    a_in_tag = '0; a_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_tag", a_out_tag, 0);
    check("rst_out_zero", a_out_zero, 1);
    a_rst_n = 1'b1;
    #1 check("rst_in_ready", a_in_ready, 1);
    @(posedge clk); #1;

    // latency
    p0 = a_pops;
    a_send(16'h00F1, 4'd4, OP_SLL, 4'd3, 16'h0F10, acc, waited);
    a_wait_pops(p0 + 1);
    check("latency", a_last_out_cyc - acc, 2);

    // back-to-back
    p0 = a_pops;
    a_out_cyc.delete();
    a_send(16'h8000, 4'd15, OP_SRA, 4'd1, 16'hFFFF, acc, waited); check("b2b_ready", waited, 0);
    a_send(16'h8000, 4'd15, OP_SRL, 4'd2, 16'h0001, acc, waited); check("b2b_ready", waited, 0);
    a_send(16'h0001, 4'd1,  OP_ROR, 4'd3, 16'h8000, acc, waited); check("b2b_ready", waited, 0);
    a_send(16'hA005, 4'd4,  OP_ROL, 4'd4, 16'h005A, acc, waited); check("b2b_ready", waited, 0);
    a_wait_pops(p0 + 4);
    for (int i = 1; i < 4 && i < a_out_cyc.size(); i++)
      check("b2b_spacing", a_out_cyc[i] - a_out_cyc[i-1], 1);

    // backpressure
    p0 = a_pops;
    a_out_ready = 1'b0;
    a_send(16'h0003, 4'd1, OP_SLL, 4'd5, 16'h0006, acc, waited);
    a_send(16'hF000, 4'd4, OP_SRL, 4'd6, 16'h0F00, acc, waited);
    check("bp_in_ready_full", a_in_ready, 0);
    fork
      a_send(16'h00FF, 4'd8, OP_ROR, 4'd7, 16'hFF00, acc, waited);
      begin
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready_held", a_in_ready, 0);
          check("bp_out_valid_held", a_out_valid, 1);
          check("bp_out_data_stable", a_out_data, 16'h0006);
          check("bp_out_tag_stable", a_out_tag, 4'd5);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    a_wait_pops(p0 + 3);

    // boundary values
    p0 = a_pops;
    for (int op = 0; op < 5; op++)
      a_send(16'h1234, 4'd0, 3'(op), 4'(op), 16'h1234, acc, waited);
    a_send(16'h1234, 4'd5,  3'b111, 4'd8, 16'h1234, acc, waited);
    a_send(16'h0001, 4'd15, OP_SLL, 4'd9, 16'h8000, acc, waited);
    a_send(16'h0001, 4'd1,  OP_SRL, 4'hA, 16'h0000, acc, waited);
    a_wait_pops(p0 + 8);

    // reset mid-flight
    a_out_ready = 1'b0;
    a_send(16'h1111, 4'd1, OP_SLL, 4'hB, 16'h2222, acc, waited);
    a_send(16'h4444, 4'd2, OP_SRL, 4'hC, 16'h1111, acc, waited);
    @(negedge clk);
    a_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_out_data", a_out_data, 0);
    check("midrst_out_zero", a_out_zero, 1);
    a_q.delete();
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    #1 check("midrst_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    p0 = a_pops;
    repeat (6) @(posedge clk);
    #1 check("midrst_no_stale", a_pops, p0);
    a_send(16'h00F0, 4'd4, OP_ROR, 4'hD, 16'h000F, acc, waited);
    a_wait_pops(p0 + 1);
    check("midrst_latency", a_last_out_cyc - acc, 2);
    a_done = 1;
  end

  // ---------------- 32-bit DUTs, random ----------------
  logic r_rst_n;
  initial begin
    r_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    r_rst_n = 1'b1;
  end

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int L = (g == 0) ? 1 : 5;

    logic        in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_cnt;
    logic [2:0]  in_op;
    logic [3:0]  in_tag, out_tag;
    logic [35:0] q[$];
    bit          done = 0;

    pipelined_shifter #(.WIDTH(32), .LVLS_PER_STG(L), .TAG_W(4)) u_dut (
      .clk(clk), .rst_n(r_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_cnt(in_cnt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_zero(out_zero)
    );

    initial out_ready = 1'b0;
    always @(posedge clk) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
      if (r_rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd%0d_unexpected_result: got data %0h with nothing outstanding",
                   g, out_data);
        end else begin
          logic [35:0] e;
          e = q.pop_front();
          check($sformatf("rnd%0d_data", g), out_data, e[31:0]);
          check($sformatf("rnd%0d_tag", g), out_tag, e[35:32]);
          check($sformatf("rnd%0d_zero", g), out_zero, e[31:0] == 32'h0);
        end
      end
    end

    initial begin
      in_valid = 1'b0; in_data = '0; in_cnt = '0; in_op = '0; in_tag = '0;
      wait (r_rst_n === 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < NRND; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        in_data  = $urandom;
        in_cnt   = 5'($urandom);
        in_op    = 3'($urandom);
        in_tag   = 4'($urandom);
        in_valid = 1'b1;
        for (int w = 0; w <= 100; w++) begin
          @(negedge clk);
          if (in_ready) begin
            q.push_back({in_tag, ref_model(32, 64'(in_data), int'(in_cnt), in_op)[31:0]});
            break;
          end
          if (w == 100) begin
            checks++; errors++;
            $display("FAIL rnd%0d_accept_timeout: op %0d not accepted", g, i);
          end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      for (int w = 0; w < 500 && q.size() != 0; w++) @(negedge clk);
      #1 check($sformatf("rnd%0d_drained", g), q.size(), 0);
      done = 1;
    end
  end

  initial begin
    wait (a_done && g_rnd[0].done && g_rnd[1].done);
    summary_done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    if (!summary_done) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: bench did not complete, done flags %0d %0d %0d",
               a_done, g_rnd[0].done, g_rnd[1].done);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
